window_5x5_gen: RTL and testbench
=================================

Name: window_5x5_gen

Overview:
- Builds the 5x5 pixel neighbourhood consumed by the edge_detection_filter_x / _y / _log stages from a raster-order 8-bit pixel stream.
- Holds four previous image lines in line buffers and a 5x5 shift window.
- Emits one 200-bit window per fully-interior centre pixel, with a valid/ready handshake and centre coordinates.

Parameters:
- IMG_WIDTH, 64, pixels per line (>=5)
- IMG_HEIGHT, 64, lines per frame (>=5)
- COORD_W, 8, width of coordinate outputs (must hold max(IMG_WIDTH, IMG_HEIGHT)-1)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pix_in  input  8  input pixel, raster order
- pix_valid  input  1  pix_in valid
- pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new frame; sampled only with pix_valid
- pix_ready  output  1  block accepts pix_in this cycle
- window_out  output  200  5x5 window; pixel (r,c) at bits [40r+8c+7 : 40r+8c]; r=0 top (oldest) row, c=0 leftmost
- win_valid  output  1  window_out/win_row/win_col valid
- win_ready  input  1  downstream accepts window
- win_row  output  COORD_W  centre row of window
- win_col  output  COORD_W  centre column of window
- win_last  output  1  this is the final window of the frame

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, rst_n). On reset all outputs are 0: pix_ready=0, win_valid=0, win_last=0, window_out=0, win_row/win_col=0. Row/column counters and window registers also clear. pix_ready rises the first cycle after rst_n deasserts.
- Line buffer contents are not reset; stale data is never emitted (see gating).
- Accept: pixel accepted when pix_valid && pix_ready. pix_ready = !win_valid || win_ready.
  - Output holds at most one window; the input stalls while an un-taken window is held.
- Counters row_cnt/col_cnt give the position of the accepted pixel.
  - Advance only on accept; col wraps IMG_WIDTH-1 -> 0 with row+1.
  - Accepting (IMG_HEIGHT-1, IMG_WIDTH-1) wraps both to 0.
  - An accept with pix_sof=1 is treated as position (0,0) regardless of counters; the next pixel is (0,1).
- Column build on accept at column c:
  - Form new column {lb0[c], lb1[c], lb2[c], lb3[c], pix_in} (top to bottom).
  - Shift the line buffers: lb0[c]<=lb1[c], lb1[c]<=lb2[c], lb2[c]<=lb3[c], lb3[c]<=pix_in.
  - Shift the 5x5 window left one column; the new column enters c=4.
- Emission: if the accepted pixel has row>=4 and col>=4:
  - Next cycle: win_valid=1, window_out = updated window, win_row=row-2, win_col=col-2.
  - win_last=1 iff the pixel was (IMG_HEIGHT-1, IMG_WIDTH-1).
  - Latency is 1 cycle from accept to win_valid.
  - (IMG_HEIGHT-4)*(IMG_WIDTH-4) windows per frame; no border windows, no padding.
- Output hold: while win_valid && !win_ready, window_out, win_row, win_col and win_last are stable.
  - win_valid clears on handshake unless a new emitting pixel is accepted in the same cycle; back-to-back windows are allowed, 1 per cycle.
- Simultaneous events:
  - Output handshake and input accept in the same cycle is legal (pix_ready=1 via win_ready).
  - pix_sof on a non-(0,0) counter position resyncs silently. Windows from the aborted frame already in the output register still complete their handshake.
- Reset mid-frame: all state clears immediately and any held window is dropped. The next accepted pixel is (0,0) whether or not pix_sof is set.
- No arithmetic beyond counters; pixels pass unmodified.

Test Plan:
- Ramp frame, IMG_WIDTH=8, IMG_HEIGHT=6, pix_in=16*row+col, win_ready=1, continuous valid -> exactly 8 windows, in this order:
  - Centres (2,2),(2,3),(2,4),(2,5),(3,2),(3,3),(3,4),(3,5).
  - First window: bits[7:0]=0x00, bits[39:32]=0x04, bits[199:192]=0x44; appears 1 cycle after pixel (4,4) is accepted.
  - win_last=1 only on centre (3,5).
- Backpressure: hold win_ready=0 for 5 cycles when the first window appears -> pix_ready=0 throughout, window_out stays 0x44..0x00 pattern stable. Release -> the next window (centre (2,3)) follows with no loss or duplication.
- Random pix_valid gaps (50%) and random win_ready, same ramp -> identical window sequence and contents to the first scenario.
- Two back-to-back frames; frame 2 uses pix_in=0xFF-(16*row+col) -> frame 2's first window bits[7:0]=0xFF. No frame-1 data appears in any frame-2 window.
- pix_sof asserted at frame-1 position (3,1), then a full frame -> the next window is centre (2,2) built only from post-sof pixels, and the full 8-window sequence follows.
- Assert rst_n=0 mid-frame while win_valid=1 -> win_valid, pix_ready, win_last and window_out are 0 immediately (asynchronously). After release, a full ramp frame reproduces the first scenario exactly.

Source files
------------

// File: rtl/window_5x5_gen.sv
// Builds a 5x5 pixel neighbourhood from a raster-order 8-bit stream using four
// line buffers and a shifting window; emits one window per interior centre pixel.
module window_5x5_gen #(
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int COORD_W    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pix_in,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic [199:0]       window_out,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [COORD_W-1:0] win_row,
    output logic [COORD_W-1:0] win_col,
    output logic               win_last
);

    localparam int AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(IMG_WIDTH - 1);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(IMG_HEIGHT - 1);
    localparam logic [COORD_W-1:0] FOUR     = COORD_W'(4);
    localparam logic [COORD_W-1:0] TWO      = COORD_W'(2);

    logic               ready_q;
    logic [COORD_W-1:0] row_q, row_d, col_q, col_d;
    logic [COORD_W-1:0] pos_row, pos_col;
    logic [COORD_W-1:0] win_row_q, win_row_d, win_col_q, win_col_d;
    logic               win_valid_q, win_valid_d;
    logic               win_last_q, win_last_d;
    logic [199:0]       window_q, window_d;
    logic [AW-1:0]      lb_idx;
    logic [7:0]         col_pix [0:4];
    logic               accept, emit;

    // Line buffer contents are never reset; row gating keeps stale lines out of windows.
    logic [7:0] lb [0:3][0:IMG_WIDTH-1];

    assign pix_ready  = ready_q && (!win_valid_q || win_ready);
    assign accept     = pix_valid && pix_ready;
    assign pos_row    = pix_sof ? '0 : row_q;
    assign pos_col    = pix_sof ? '0 : col_q;
    assign lb_idx     = pos_col[AW-1:0];
    assign emit       = accept && (pos_row >= FOUR) && (pos_col >= FOUR);

    assign window_out = window_q;
    assign win_valid  = win_valid_q;
    assign win_row    = win_row_q;
    assign win_col    = win_col_q;
    assign win_last   = win_last_q;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col_pix
            assign col_pix[gi] = lb[gi][lb_idx];
        end
    endgenerate
    assign col_pix[4] = pix_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb[0][lb_idx] <= lb[1][lb_idx];
            lb[1][lb_idx] <= lb[2][lb_idx];
            lb[2][lb_idx] <= lb[3][lb_idx];
            lb[3][lb_idx] <= pix_in;
        end
    end

    always_comb begin
        window_d = window_q;
        if (accept) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    window_d[40*r + 8*c +: 8] = window_q[40*r + 8*(c+1) +: 8];
                end
                window_d[40*r + 32 +: 8] = col_pix[r];
            end
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (pos_col == LAST_COL) begin
                col_d = '0;
                row_d = (pos_row == LAST_ROW) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end
    end

    always_comb begin
        win_valid_d = win_valid_q;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
        win_last_d  = win_last_q;
        if (emit) begin
            win_valid_d = 1'b1;
            win_row_d   = pos_row - TWO;
            win_col_d   = pos_col - TWO;
            win_last_d  = (pos_row == LAST_ROW) && (pos_col == LAST_COL);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            window_q    <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            win_last_q  <= 1'b0;
        end else begin
            ready_q     <= 1'b1;
            row_q       <= row_d;
            col_q       <= col_d;
            window_q    <= window_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            win_last_q  <= win_last_d;
        end
    end

endmodule

// File: tb/tb_window_5x5_gen.sv
// Scoreboard bench for window_5x5_gen: a frame-image model predicts every window
// at accept time; windows are popped and compared on each output handshake.
module tb_window_5x5_gen;
    localparam int W = 8;
    localparam int H = 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   pix_in = 8'h00;
    logic         pix_valid = 1'b0;
    logic         pix_sof = 1'b0;
    logic         pix_ready;
    logic [199:0] window_out;
    logic         win_valid;
    logic         win_ready = 1'b1;
    logic [7:0]   win_row, win_col;
    logic         win_last;

    always #5 clk = ~clk;

    window_5x5_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .COORD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_ready(pix_ready), .window_out(window_out),
        .win_valid(win_valid), .win_ready(win_ready), .win_row(win_row),
        .win_col(win_col), .win_last(win_last)
    );

    typedef struct packed {
        logic [199:0] win;
        logic [7:0]   row;
        logic [7:0]   col;
        logic         last;
    } exp_t;

    exp_t         sbq[$];
    exp_t         e_pop, e_push;
    int           total = 0;
    int           bad = 0;
    logic [7:0]   img [0:H-1][0:W-1];
    int           m_row = 0;
    int           m_col = 0;
    bit           pend = 0;
    int           win_cnt = 0;
    int           rdy_mode = 0;
    logic [199:0] first_win = '0;
    logic [199:0] second_first = '0;
    logic [199:0] hold_win;

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Output monitor / scoreboard, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (pend) chk("latency", 200'(win_valid), 200'(1));
            pend = 0;
            if (win_valid && win_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_win", 200'(sbq.size()), 200'(1));
                end else begin
                    e_pop = sbq.pop_front();
                    chk("win", window_out, e_pop.win);
                    chk("row", 200'(win_row), 200'(e_pop.row));
                    chk("col", 200'(win_col), 200'(e_pop.col));
                    chk("last", 200'(win_last), 200'(e_pop.last));
                    $display("win %0d centre=(%0d,%0d) last=%0b", win_cnt, win_row, win_col, win_last);
                    if (win_cnt == 0) first_win = window_out;
                    if (win_cnt == 8) second_first = window_out;
                    win_cnt++;
                end
            end
            if (pix_valid && pix_ready) begin
                if (pix_sof) begin
                    m_row = 0;
                    m_col = 0;
                end
                img[m_row][m_col] = pix_in;
                if (m_row >= 4 && m_col >= 4) begin
                    for (int r = 0; r < 5; r++)
                        for (int c = 0; c < 5; c++)
                            e_push.win[40*r + 8*c +: 8] = img[m_row-4+r][m_col-4+c];
                    e_push.row  = 8'(m_row - 2);
                    e_push.col  = 8'(m_col - 2);
                    e_push.last = (m_row == H-1) && (m_col == W-1);
                    sbq.push_back(e_push);
                    pend = 1;
                end
                if (m_col == W-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_mode == 1) win_ready = ($urandom_range(0, 1) == 1);
    end

    task automatic drive_pix(input logic [7:0] v, input logic sof, input bit gaps);
        bit done = 0;
        int guard = 0;
        while (!done) begin
            pix_valid = !gaps || ($urandom_range(0, 1) == 1);
            pix_in    = v;
            pix_sof   = sof;
            @(negedge clk);
            done = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            guard++;
            if (!done && guard > 2000) begin
                chk("accept_timeout", 200'(pix_ready), 200'(1));
                done = 1;
            end
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic drive_frame(input bit inv, input bit gaps, input bit sof_first);
        logic [7:0] v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                v = 8'(16*r + c);
                if (inv) v = 8'hFF - v;
                drive_pix(v, sof_first && r == 0 && c == 0, gaps);
            end
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((sbq.size() != 0 || win_valid) && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain", 200'(sbq.size()), 200'(0));
    endtask

    task automatic check_first_ramp(input string tag);
        chk({tag, "_b0"}, 200'(first_win[7:0]), 200'(8'h00));
        chk({tag, "_b4"}, 200'(first_win[39:32]), 200'(8'h04));
        chk({tag, "_b24"}, 200'(first_win[199:192]), 200'(8'h44));
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_ready", 200'(pix_ready), 200'(0));
        chk("rst_valid", 200'(win_valid), 200'(0));
        chk("rst_window", window_out, 200'(0));
        chk("rst_row", 200'(win_row), 200'(0));
        chk("rst_col", 200'(win_col), 200'(0));
        chk("rst_last", 200'(win_last), 200'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk("ready_pre", 200'(pix_ready), 200'(0));
        @(posedge clk);
        #1;
        chk("ready_post", 200'(pix_ready), 200'(1));

        // Ramp frame, continuous
        win_cnt = 0;
        drive_frame(0, 0, 1);
        wait_drain();
        chk("ramp_nwin", 200'(win_cnt), 200'(8));
        check_first_ramp("ramp");

        // Backpressure on the first window
        rdy_mode = 2;
        win_cnt = 0;
        fork
            drive_frame(0, 0, 1);
            begin
                int g = 0;
                while (!win_valid && g < 500) begin
                    @(posedge clk);
                    #1;
                    g++;
                end
                chk("bp_wait", 200'(win_valid), 200'(1));
                hold_win = window_out;
                win_ready = 1'b0;
                chk("bp_top", 200'(hold_win[199:192]), 200'(8'h44));
                repeat (5) begin
                    @(negedge clk);
                    chk("bp_ready", 200'(pix_ready), 200'(0));
                    chk("bp_hold", window_out, hold_win);
                    @(posedge clk);
                    #1;
                end
                win_ready = 1'b1;
            end
        join
        wait_drain();
        chk("bp_nwin", 200'(win_cnt), 200'(8));

        // Random input gaps and output readiness
        rdy_mode = 1;
        win_cnt = 0;
        drive_frame(0, 1, 1);
        wait_drain();
        rdy_mode = 0;
        win_ready = 1'b1;
        chk("rand_nwin", 200'(win_cnt), 200'(8));
        check_first_ramp("rand");

        // Two back-to-back frames, second inverted
        win_cnt = 0;
        drive_frame(0, 0, 1);
        drive_frame(1, 0, 1);
        wait_drain();
        chk("b2b_nwin", 200'(win_cnt), 200'(16));
        chk("f2_b0", 200'(second_first[7:0]), 200'(8'hFF));

        // Partial frame up to (3,0), then sof lands on counter position (3,1)
        win_cnt = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                if (r < 3 || c == 0) drive_pix(8'(8'hA0 + c), 1'b0, 0);
        drive_frame(0, 0, 1);
        wait_drain();
        chk("sof_nwin", 200'(win_cnt), 200'(8));
        check_first_ramp("sof");

        // Reset while a window is held
        rdy_mode = 2;
        win_ready = 1'b0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < W; c++)
                if (r < 4 || c <= 4) drive_pix(8'(16*r + c), r == 0 && c == 0, 0);
        chk("pre_rst_valid", 200'(win_valid), 200'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("mr_valid", 200'(win_valid), 200'(0));
        chk("mr_ready", 200'(pix_ready), 200'(0));
        chk("mr_last", 200'(win_last), 200'(0));
        chk("mr_window", window_out, 200'(0));
        sbq.delete();
        pend = 0;
        m_row = 0;
        m_col = 0;
        win_cnt = 0;
        win_ready = 1'b1;
        rdy_mode = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_frame(0, 0, 0);
        wait_drain();
        chk("mr_nwin", 200'(win_cnt), 200'(8));
        check_first_ramp("mr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
